// File: rtl/imem_wb_loader_if.sv
// Wishbone classic slave bundle between the Caravel bus and imem_wb_loader.
interface imem_wb_loader_if;
  logic        wbs_stb_i;
  logic        wbs_cyc_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport master (
    output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o
  );

  modport slave (
    input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/imem_wb_loader.sv
// Wishbone loader for the SLRV instruction SRAM port 0, plus core_halt and write counter.
// Define IMEM_READBACK_EN to enable SRAM readback; otherwise memory reads return 0.
module imem_wb_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int unsigned ADDR_W    = 9
) (
  input  logic              wb_clk_i,
  input  logic              rst_n,
  imem_wb_loader_if.slave   wb,
  output logic              csb0,
  output logic              web0,
  output logic [3:0]        wmask0,
  output logic [ADDR_W-1:0] addr0,
  output logic [31:0]       din0,
  input  logic [31:0]       dout0,
  output logic              core_halt
);

  typedef enum logic [2:0] {
    IDLE,
    MEM_WR,
`ifdef IMEM_READBACK_EN
    MEM_RD,
    RD_WAIT,
`endif
    ACK
  } state_t;

  state_t            state_reg, state_next;
  logic              ack_reg, ack_next;
  logic [31:0]       dat_reg, dat_next;
  logic              csb0_reg, csb0_next;
  logic              web0_reg, web0_next;
  logic [3:0]        wmask0_reg, wmask0_next;
  logic [ADDR_W-1:0] addr0_reg, addr0_next;
  logic [31:0]       din0_reg, din0_next;
  logic              halt_reg, halt_next;
  logic [15:0]       wr_count_reg, wr_count_next;

  logic hit, is_mem, is_ctrl, is_wrcnt;
  logic unused_bits;

  assign hit      = wb.wbs_cyc_i & wb.wbs_stb_i & (wb.wbs_adr_i[31:12] == BASE_ADDR[31:12]);
  assign is_mem   = ~wb.wbs_adr_i[11];
  assign is_ctrl  = (wb.wbs_adr_i[11:2] == 10'h200);
  assign is_wrcnt = (wb.wbs_adr_i[11:2] == 10'h201);

`ifdef IMEM_READBACK_EN
  assign unused_bits = ^wb.wbs_adr_i[1:0];
`else
  assign unused_bits = ^{wb.wbs_adr_i[1:0], dout0};
`endif

  always_comb begin
    state_next    = state_reg;
    ack_next      = 1'b0;
    dat_next      = '0;
    csb0_next     = 1'b1;
    web0_next     = 1'b1;
    wmask0_next   = '0;
    addr0_next    = addr0_reg;
    din0_next     = din0_reg;
    halt_next     = halt_reg;
    wr_count_next = wr_count_reg;

    case (state_reg)
      IDLE: begin
        if (hit) begin
          state_next = ACK;
          ack_next   = 1'b1;
          if (is_mem) begin
            // Writes while the core runs are dropped so they never race its fetches.
            if (wb.wbs_we_i && halt_reg && (wb.wbs_sel_i != 4'h0)) begin
              state_next  = MEM_WR;
              ack_next    = 1'b0;
              csb0_next   = 1'b0;
              web0_next   = 1'b0;
              wmask0_next = wb.wbs_sel_i;
              addr0_next  = wb.wbs_adr_i[ADDR_W+1:2];
              din0_next   = wb.wbs_dat_i;
            end
`ifdef IMEM_READBACK_EN
            else if (!wb.wbs_we_i) begin
              state_next = MEM_RD;
              ack_next   = 1'b0;
              csb0_next  = 1'b0;
              addr0_next = wb.wbs_adr_i[ADDR_W+1:2];
            end
`endif
          end else if (is_ctrl) begin
            if (wb.wbs_we_i) begin
              halt_next = wb.wbs_dat_i[0];
              if (wb.wbs_dat_i[1]) wr_count_next = '0;
            end else begin
              dat_next = {31'b0, halt_reg};
            end
          end else if (is_wrcnt && !wb.wbs_we_i) begin
            dat_next = {16'b0, wr_count_reg};
          end
        end
      end
      MEM_WR: begin
        state_next = ACK;
        ack_next   = 1'b1;
        if (wr_count_reg != 16'hFFFF) wr_count_next = wr_count_reg + 16'd1;
      end
`ifdef IMEM_READBACK_EN
      MEM_RD: begin
        state_next = RD_WAIT;
      end
      RD_WAIT: begin
        state_next = ACK;
        ack_next   = 1'b1;
        dat_next   = dout0;
      end
`endif
      ACK: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      ack_reg      <= 1'b0;
      dat_reg      <= '0;
      csb0_reg     <= 1'b1;
      web0_reg     <= 1'b1;
      wmask0_reg   <= '0;
      addr0_reg    <= '0;
      din0_reg     <= '0;
      halt_reg     <= 1'b1;
      wr_count_reg <= '0;
    end else begin
      state_reg    <= state_next;
      ack_reg      <= ack_next;
      dat_reg      <= dat_next;
      csb0_reg     <= csb0_next;
      web0_reg     <= web0_next;
      wmask0_reg   <= wmask0_next;
      addr0_reg    <= addr0_next;
      din0_reg     <= din0_next;
      halt_reg     <= halt_next;
      wr_count_reg <= wr_count_next;
    end
  end

  assign wb.wbs_ack_o = ack_reg;
  assign wb.wbs_dat_o = dat_reg;
  assign csb0         = csb0_reg;
  assign web0         = web0_reg;
  assign wmask0       = wmask0_reg;
  assign addr0        = addr0_reg;
  assign din0         = din0_reg;
  assign core_halt    = halt_reg;

endmodule

// File: tb/tb_imem_wb_loader.sv
// Directed bench for imem_wb_loader with a behavioural SRAM on port 0.
module tb_imem_wb_loader;
  logic        clk;
  logic        rst_n;
  logic        csb0, web0, core_halt;
  logic [3:0]  wmask0;
  logic [8:0]  addr0;
  logic [31:0] din0, dout0;

  imem_wb_loader_if wb ();

  imem_wb_loader #(.BASE_ADDR(32'h3000_0000), .ADDR_W(9)) dut (
    .wb_clk_i (clk),
    .rst_n    (rst_n),
    .wb       (wb),
    .csb0     (csb0),
    .web0     (web0),
    .wmask0   (wmask0),
    .addr0    (addr0),
    .din0     (din0),
    .dout0    (dout0),
    .core_halt(core_halt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] sram [512];
  always @(posedge clk) begin
    if (!csb0) begin
      if (!web0) begin
        for (int b = 0; b < 4; b++)
          if (wmask0[b]) sram[addr0][8*b +: 8] <= din0[8*b +: 8];
      end else begin
        dout0 <= sram[addr0];
      end
    end
  end

  int vectors = 0;
  int miscompares = 0;
  int late_ack = 0;
  int stray_dat = 0;

  logic [31:0] rdat;
  int          lat, csb_lo;
  logic [8:0]  seen_addr;
  logic [3:0]  seen_mask;
  logic        seen_web;
  logic [31:0] seen_din;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic bus_idle();
    wb.wbs_cyc_i = 1'b0;
    wb.wbs_stb_i = 1'b0;
    wb.wbs_we_i  = 1'b0;
    wb.wbs_sel_i = 4'h0;
    wb.wbs_adr_i = 32'h0;
    wb.wbs_dat_i = 32'h0;
  endtask

  // Called #1 after a rising edge; lat=0 means no ack within the budget.
  task automatic xfer(input logic we, input logic [31:0] adr, input logic [31:0] wdat,
                      input logic [3:0] sel);
    lat = 0; csb_lo = 0; rdat = 32'h0;
    wb.wbs_cyc_i = 1'b1;
    wb.wbs_stb_i = 1'b1;
    wb.wbs_we_i  = we;
    wb.wbs_sel_i = sel;
    wb.wbs_adr_i = adr;
    wb.wbs_dat_i = wdat;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk); #1;
      if (!csb0) begin
        csb_lo++;
        seen_addr = addr0; seen_mask = wmask0; seen_web = web0; seen_din = din0;
      end
      if (wb.wbs_ack_o) begin
        lat  = i;
        rdat = wb.wbs_dat_o;
        break;
      end
    end
    bus_idle();
    @(posedge clk); #1;
    if (wb.wbs_ack_o) late_ack++;
    if (wb.wbs_dat_o != 32'h0) stray_dat++;
    $display("xfer we=%0b adr=%08h wdat=%08h sel=%h -> lat=%0d rdat=%08h csb_lo=%0d",
             we, adr, wdat, sel, lat, rdat, csb_lo);
  endtask

  initial begin
    bus_idle();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_core_halt", {31'b0, core_halt}, 32'h1);
    check("rst_csb0",      {31'b0, csb0},      32'h1);
    check("rst_web0",      {31'b0, web0},      32'h1);
    check("rst_wmask0",    {28'b0, wmask0},    32'h0);
    check("rst_addr0",     {23'b0, addr0},     32'h0);
    check("rst_ack",       {31'b0, wb.wbs_ack_o}, 32'h0);
    check("rst_dat",       wb.wbs_dat_o,       32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    xfer(1'b0, 32'h3000_0800, 32'h0, 4'hF);
    check("ctrl_rd_lat", lat, 1);
    check("ctrl_rd_dat", rdat, 32'h1);

    xfer(1'b1, 32'h3000_0010, 32'hDEAD_BEEF, 4'hF);
    check("wr_lat",    lat, 2);
    check("wr_csb_lo", csb_lo, 1);
    check("wr_addr0",  {23'b0, seen_addr}, 32'h4);
    check("wr_wmask0", {28'b0, seen_mask}, 32'hF);
    check("wr_web0",   {31'b0, seen_web},  32'h0);
    check("wr_din0",   seen_din, 32'hDEAD_BEEF);
    check("wr_sram",   sram[4], 32'hDEAD_BEEF);
    xfer(1'b0, 32'h3000_0804, 32'h0, 4'hF);
    check("wrcnt_1", rdat, 32'h1);

    xfer(1'b0, 32'h3000_0010, 32'h0, 4'hF);
`ifdef IMEM_READBACK_EN
    check("mem_rd_lat",    lat, 3);
    check("mem_rd_dat",    rdat, 32'hDEAD_BEEF);
    check("mem_rd_csb_lo", csb_lo, 1);
    check("mem_rd_web0",   {31'b0, seen_web}, 32'h1);
`else
    check("mem_rd_lat",    lat, 1);
    check("mem_rd_dat",    rdat, 32'h0);
    check("mem_rd_csb_lo", csb_lo, 0);
`endif

    // Byte-lane write: only lane 1 of 0x11223344 (0x33) lands.
    xfer(1'b1, 32'h3000_0010, 32'h1122_3344, 4'h2);
    check("bw_lat",    lat, 2);
    check("bw_wmask0", {28'b0, seen_mask}, 32'h2);
    check("bw_sram",   sram[4], 32'hDEAD_33EF);
    xfer(1'b1, 32'h3000_0014, 32'h5555_5555, 4'h0);
    check("sel0_lat",    lat, 1);
    check("sel0_csb_lo", csb_lo, 0);
    xfer(1'b0, 32'h3000_0804, 32'h0, 4'hF);
    check("wrcnt_2", rdat, 32'h2);

    xfer(1'b1, 32'h3000_0800, 32'h0, 4'hF);
    check("ctrl_wr_lat", lat, 1);
    check("run_halt",    {31'b0, core_halt}, 32'h0);
    xfer(1'b0, 32'h3000_0800, 32'h0, 4'hF);
    check("ctrl_rd_0",   rdat, 32'h0);
    xfer(1'b1, 32'h3000_0020, 32'hCAFE_F00D, 4'hF);
    check("drop_lat",    lat, 1);
    check("drop_csb_lo", csb_lo, 0);
    xfer(1'b0, 32'h3000_0804, 32'h0, 4'hF);
    check("wrcnt_drop", rdat, 32'h2);

    xfer(1'b1, 32'h3000_0800, 32'h3, 4'hF);
    check("clr_halt", {31'b0, core_halt}, 32'h1);
    xfer(1'b0, 32'h3000_0800, 32'h0, 4'hF);
    check("clr_ctrl_rd", rdat, 32'h1);
    xfer(1'b0, 32'h3000_0804, 32'h0, 4'hF);
    check("clr_wrcnt", rdat, 32'h0);

    xfer(1'b0, 32'h3000_0900, 32'h0, 4'hF);
    check("hole_rd_lat", lat, 1);
    check("hole_rd_dat", rdat, 32'h0);
    xfer(1'b1, 32'h3000_0900, 32'h1, 4'hF);
    check("hole_wr_lat", lat, 1);
    check("hole_halt",   {31'b0, core_halt}, 32'h1);
    xfer(1'b0, 32'h3100_0000, 32'h0, 4'hF);
    check("miss_noack",  lat, 0);

    // Abort a transaction in flight with reset.
`ifdef IMEM_READBACK_EN
    wb.wbs_cyc_i = 1'b1; wb.wbs_stb_i = 1'b1; wb.wbs_we_i = 1'b0;
    wb.wbs_sel_i = 4'hF; wb.wbs_adr_i = 32'h3000_0010;
    @(posedge clk); #1;
    check("abort_csb_active", {31'b0, csb0}, 32'h0);
    @(posedge clk); #1;
`else
    wb.wbs_cyc_i = 1'b1; wb.wbs_stb_i = 1'b1; wb.wbs_we_i = 1'b1;
    wb.wbs_sel_i = 4'hF; wb.wbs_adr_i = 32'h3000_0030; wb.wbs_dat_i = 32'h1234_5678;
    sram[12] = 32'h0;
    @(posedge clk); #1;
    check("abort_csb_active", {31'b0, csb0}, 32'h0);
`endif
    rst_n = 1'b0;
    #1;
    check("abort_csb", {31'b0, csb0}, 32'h1);
    check("abort_ack", {31'b0, wb.wbs_ack_o}, 32'h0);
    bus_idle();
    begin
      int acks = 0;
      for (int i = 0; i < 3; i++) begin
        @(posedge clk); #1;
        if (wb.wbs_ack_o) acks++;
      end
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
        @(posedge clk); #1;
        if (wb.wbs_ack_o) acks++;
      end
      check("abort_no_ack", acks, 0);
    end
`ifdef IMEM_READBACK_EN
    xfer(1'b0, 32'h3000_0010, 32'h0, 4'hF);
    check("retry_rd_lat", lat, 3);
    check("retry_rd_dat", rdat, 32'hDEAD_33EF);
`else
    check("abort_sram", sram[12], 32'h0);
    xfer(1'b1, 32'h3000_0030, 32'h1234_5678, 4'hF);
    check("retry_wr_lat", lat, 2);
    check("retry_sram",   sram[12], 32'h1234_5678);
`endif

    check("ack_one_cycle", late_ack, 0);
    check("dat_idle_zero", stray_dat, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
